// File: rtl/flash_emulator.sv
// Emulated 16-bit NOR flash: word array behind a command interface with word program and block erase.
// Optional build macro FLASH_EMU_VPEN_CHECK_EN rejects program/erase confirms while vpen is low.
module flash_emulator #(
    parameter int FLASH_ADDR_SIZE = 22,
    parameter int MEM_ADDR_BITS   = 10,
    parameter int BLOCK_BITS      = 6,
    parameter int PROG_CYCLES     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLASH_ADDR_SIZE:0] flash_addr,
    inout  wire  [15:0]              flash_data,
    input  logic [7:0]               flash_ctl,
    output logic                     busy
);

    localparam int WORDS   = 1 << MEM_ADDR_BITS;
    localparam int PROG_W  = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
    localparam int CNT_W   = (BLOCK_BITS > PROG_W) ? BLOCK_BITS : PROG_W;
    localparam int BLK_W   = MEM_ADDR_BITS - BLOCK_BITS;

    typedef enum logic [2:0] {
        READY,
        PROG_SETUP,
        ERASE_SETUP,
        PROG_BUSY,
        ERASE_BUSY
    } state_t;

    typedef enum logic {
        MODE_ARRAY,
        MODE_STATUS
    } mode_t;

    state_t                   state;
    mode_t                    mode;
    logic                     sr_ready;
    logic                     sr_erase_err;
    logic                     sr_prog_err;
    logic                     sr_vpen_err;
    logic [CNT_W-1:0]         cnt;
    logic [BLK_W-1:0]         erase_block;
    logic                     we_prev;
    logic [MEM_ADDR_BITS-1:0] rd_addr;

    // Contents are stored inverted so a cleared array reads back as erased (all ones).
    logic [15:0]              mem_n [WORDS];

    logic                     ctl_ce_n;
    logic                     ctl_oe_n;
    logic                     ctl_rp_n;
    logic                     ctl_we_n;
    logic                     vpen_ok;
    logic [MEM_ADDR_BITS-1:0] word_idx;
    logic [MEM_ADDR_BITS-1:0] erase_addr;
    logic [7:0]               cmd;
    logic [7:0]               sr;
    logic [15:0]              rd_data;
    logic                     write_cycle;
    logic                     prog_commit;
    logic                     erase_step;
    logic                     drive_en;
    logic                     unused_bits;

    assign ctl_ce_n    = flash_ctl[6];
    assign ctl_oe_n    = flash_ctl[3];
    assign ctl_rp_n    = flash_ctl[2];
    assign ctl_we_n    = flash_ctl[0];
    assign unused_bits = ^{flash_addr[FLASH_ADDR_SIZE:MEM_ADDR_BITS+1], flash_addr[0],
                           flash_ctl[7], flash_ctl[5:4], flash_ctl[1]};

`ifdef FLASH_EMU_VPEN_CHECK_EN
    assign vpen_ok = flash_ctl[1];
`else
    assign vpen_ok = 1'b1;
`endif

    assign word_idx    = flash_addr[MEM_ADDR_BITS:1];
    assign erase_addr  = {erase_block, cnt[BLOCK_BITS-1:0]};
    assign cmd         = flash_data[7:0];
    assign sr          = {sr_ready, 1'b0, sr_erase_err, sr_prog_err, sr_vpen_err, 3'b000};
    assign write_cycle = ctl_we_n && !we_prev && !ctl_ce_n && ctl_rp_n;
    assign prog_commit = (state == PROG_SETUP) && write_cycle && vpen_ok;
    assign erase_step  = (state == ERASE_BUSY) && ctl_rp_n;
    assign rd_data     = (mode == MODE_STATUS) ? {8'h00, sr} : ~mem_n[rd_addr];
    assign drive_en    = !rst && !ctl_ce_n && !ctl_oe_n && ctl_we_n && ctl_rp_n;
    assign flash_data  = drive_en ? rd_data : 16'bz;

    // Programming can only clear bits; erase walks the latched block one word per clock.
    always_ff @(posedge clk) begin
        if (prog_commit) begin
            mem_n[word_idx] <= mem_n[word_idx] | ~flash_data;
        end else if (erase_step) begin
            mem_n[erase_addr] <= '0;
        end
    end

    // Command state machine; rp low acts as a synchronous abort back to a clean ready state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= READY;
            mode         <= MODE_ARRAY;
            sr_ready     <= 1'b1;
            sr_erase_err <= 1'b0;
            sr_prog_err  <= 1'b0;
            sr_vpen_err  <= 1'b0;
            busy         <= 1'b0;
            cnt          <= '0;
            erase_block  <= '0;
            we_prev      <= 1'b1;
            rd_addr      <= '0;
        end else begin
            we_prev <= ctl_we_n;
            rd_addr <= word_idx;
            if (!ctl_rp_n) begin
                state        <= READY;
                mode         <= MODE_ARRAY;
                sr_ready     <= 1'b1;
                sr_erase_err <= 1'b0;
                sr_prog_err  <= 1'b0;
                sr_vpen_err  <= 1'b0;
                busy         <= 1'b0;
                cnt          <= '0;
            end else begin
                case (state)
                    READY: begin
                        if (write_cycle) begin
                            case (cmd)
                                8'hFF: mode <= MODE_ARRAY;
                                8'h70: mode <= MODE_STATUS;
                                8'h50: begin
                                    sr_erase_err <= 1'b0;
                                    sr_prog_err  <= 1'b0;
                                    sr_vpen_err  <= 1'b0;
                                end
                                8'h40: state <= PROG_SETUP;
                                8'h20: state <= ERASE_SETUP;
                                default: ;
                            endcase
                        end
                    end
                    PROG_SETUP: begin
                        if (write_cycle) begin
                            mode <= MODE_STATUS;
                            if (vpen_ok) begin
                                sr_ready <= 1'b0;
                                busy     <= 1'b1;
                                cnt      <= '0;
                                state    <= PROG_BUSY;
                            end else begin
                                sr_vpen_err <= 1'b1;
                                sr_prog_err <= 1'b1;
                                state       <= READY;
                            end
                        end
                    end
                    ERASE_SETUP: begin
                        if (write_cycle) begin
                            mode <= MODE_STATUS;
                            if (cmd == 8'hD0 && vpen_ok) begin
                                erase_block <= word_idx[MEM_ADDR_BITS-1:BLOCK_BITS];
                                sr_ready    <= 1'b0;
                                busy        <= 1'b1;
                                cnt         <= '0;
                                state       <= ERASE_BUSY;
                            end else if (cmd == 8'hD0) begin
                                sr_vpen_err  <= 1'b1;
                                sr_erase_err <= 1'b1;
                                state        <= READY;
                            end else begin
                                sr_erase_err <= 1'b1;
                                sr_prog_err  <= 1'b1;
                                state        <= READY;
                            end
                        end
                    end
                    PROG_BUSY: begin
                        if (cnt == CNT_W'(PROG_CYCLES - 1)) begin
                            sr_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= READY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ERASE_BUSY: begin
                        if (cnt == CNT_W'((1 << BLOCK_BITS) - 1)) begin
                            sr_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= READY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= READY;
                endcase
            end
        end
    end

endmodule
